// File: rtl/vga_pattern_gen.sv
// Pixel-data stage behind the VGA timing driver: four selectable test patterns
// with syncs and data-enable delay-matched to the colour (2-cycle latency).
module vga_pattern_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter logic [1:0]  INIT_MODE       = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [7:0] blk_in,
  input  logic       btn_n,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic [1:0] mode_o
);

  localparam logic [19:0] DbLast = 20'(DEBOUNCE_CYCLES - 1);

  logic        hsync_d1, vsync_d1, de_d1;
  logic [7:0]  blk_d1;
  logic [9:0]  line_cnt;
  logic [7:0]  frame_cnt;
  logic [1:0]  mode_active, mode_pending;
  logic        btn_s1, btn_s2, btn_db;
  logic [19:0] db_cnt;
  logic        vsync_fall, de_fall;
  logic [7:0]  scroll;
  logic [23:0] rgb_d, rgb_q;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Edges are detected against stage 1 so they line up with the pixel being coloured.
  assign vsync_fall = vsync_d1 & ~vsync_in;
  assign de_fall    = de_d1 & ~de_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_d1 <= 1'b1;
      vsync_d1 <= 1'b1;
      de_d1    <= 1'b0;
      blk_d1   <= '0;
      hsync_o  <= 1'b1;
      vsync_o  <= 1'b1;
      de_o     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hsync_d1 <= hsync_in;
      vsync_d1 <= vsync_in;
      de_d1    <= de_in;
      blk_d1   <= blk_in;
      hsync_o  <= hsync_d1;
      vsync_o  <= vsync_d1;
      de_o     <= de_d1;
      rgb_q    <= rgb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (!vsync_d1) begin
        line_cnt <= '0;
      end else if (de_fall && line_cnt != 10'd1023) begin
        line_cnt <= line_cnt + 10'd1;
      end
      if (vsync_fall) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
    end
  end

  // A press landing on a vsync fall applies the old pending value; the
  // increment is picked up at the following frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db       <= 1'b1;
      db_cnt       <= '0;
      mode_pending <= INIT_MODE;
      mode_active  <= INIT_MODE;
    end else begin
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DbLast) begin
        db_cnt <= '0;
        btn_db <= ~btn_db;
        if (btn_db) begin
          mode_pending <= mode_pending + 2'd1;
        end
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
      if (vsync_fall) begin
        mode_active <= mode_pending;
      end
    end
  end

  always_comb begin
    rgb_d  = '0;
    scroll = blk_d1 + frame_cnt;
    if (de_d1) begin
      unique case (mode_active)
        2'd0:    rgb_d = bar_colour(blk_d1[7:5]);
        2'd1:    rgb_d = {blk_d1, blk_d1, blk_d1};
        2'd2:    rgb_d = (blk_d1[4] ^ line_cnt[5]) ? 24'hFFFFFF : 24'h000000;
        default: rgb_d = bar_colour(scroll[7:5]);
      endcase
    end
  end

  assign vga_r  = rgb_q[23:16];
  assign vga_g  = rgb_q[15:8];
  assign vga_b  = rgb_q[7:0];
  assign mode_o = mode_active;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: latency, patterns, blanking, debounce,
// frame-boundary mode apply and asynchronous reset.
module tb_vga_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       hsync_in, vsync_in, de_in, btn_n;
  logic [7:0] blk_in;
  logic       hsync_o, vsync_o, de_o;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [1:0] mode_o;

  int n_checks;
  int n_fail;
  int frames;

  vga_pattern_gen #(
    .DEBOUNCE_CYCLES(4),
    .INIT_MODE      (2'd0)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .de_in   (de_in),
    .blk_in  (blk_in),
    .btn_n   (btn_n),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .de_o    (de_o),
    .vga_r   (vga_r),
    .vga_g   (vga_g),
    .vga_b   (vga_b),
    .mode_o  (mode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vga_r, vga_g, vga_b};
  endfunction

  // Drive one pixel, hold it through the pipeline, compare colour at n+2.
  task automatic pixel_check(input string tag, input logic de, input logic [7:0] blk,
                             input logic [23:0] exp);
    de_in  = de;
    blk_in = blk;
    step();
    step();
    check_val(tag, rgb(), {8'h00, exp});
  endtask

  task automatic press(input int cycles);
    btn_n = 1'b0;
    repeat (cycles) step();
    btn_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    step();
    step();
    check_val("vsync_o_low", {31'd0, vsync_o}, 32'd0);
    vsync_in = 1'b1;
    step();
    step();
    frames++;
  endtask

  task automatic de_pulse();
    de_in = 1'b1;
    step();
    de_in = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    frames   = 0;
    rst_n    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    de_in    = 1'b1;
    blk_in   = 8'h55;
    btn_n    = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_hsync", {31'd0, hsync_o}, 32'd1);
    check_val("rst_vsync", {31'd0, vsync_o}, 32'd1);
    check_val("rst_de", {31'd0, de_o}, 32'd0);
    check_val("rst_rgb", rgb(), 32'd0);
    check_val("rst_mode", {30'd0, mode_o}, 32'd0);

    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    blk_in   = 8'h00;
    btn_n    = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Latency and colour bars in mode 0.
    de_in    = 1'b1;
    blk_in   = 8'h40;
    hsync_in = 1'b0;
    step();
    blk_in   = 8'hE0;
    hsync_in = 1'b1;
    step();
    check_val("bar_40", rgb(), 32'h0000FFFF);
    check_val("hsync_lat", {31'd0, hsync_o}, 32'd0);
    check_val("de_lat", {31'd0, de_o}, 32'd1);
    blk_in = 8'h00;
    step();
    check_val("bar_E0", rgb(), 32'h00000000);
    check_val("hsync_back", {31'd0, hsync_o}, 32'd1);
    step();
    check_val("bar_00", rgb(), 32'h00FFFFFF);
    de_in = 1'b0;
    step();

    // Debounce: glitch ignored, long press applied only at frame boundary.
    press(2);
    vsync_pulse();
    check_val("glitch_mode", {30'd0, mode_o}, 32'd0);
    press(10);
    check_val("press_wait", {30'd0, mode_o}, 32'd0);
    vsync_pulse();
    check_val("press_apply", {30'd0, mode_o}, 32'd1);
    vsync_pulse();
    check_val("release_none", {30'd0, mode_o}, 32'd1);

    // Gray ramp and blanking.
    pixel_check("blank_80", 1'b0, 8'h80, 24'h000000);
    check_val("blank_de", {31'd0, de_o}, 32'd0);
    pixel_check("gray_80", 1'b1, 8'h80, 24'h808080);
    pixel_check("gray_3C", 1'b1, 8'h3C, 24'h3C3C3C);
    de_in = 1'b0;
    step();

    // Checker: line_cnt starts at 0 after vsync.
    press(10);
    vsync_pulse();
    check_val("mode2", {30'd0, mode_o}, 32'd2);
    pixel_check("chk_l0_10", 1'b1, 8'h10, 24'hFFFFFF);
    pixel_check("chk_l0_00", 1'b1, 8'h00, 24'h000000);
    repeat (32) de_pulse();
    pixel_check("chk_l32_10", 1'b1, 8'h10, 24'h000000);
    pixel_check("chk_l32_00", 1'b1, 8'h00, 24'hFFFFFF);
    de_in = 1'b0;
    step();
    vsync_pulse();
    pixel_check("chk_vclr", 1'b1, 8'h10, 24'hFFFFFF);
    de_in = 1'b0;
    step();

    // Scrolling bars at frame_cnt = 32.
    press(10);
    while (frames < 32) vsync_pulse();
    check_val("mode3", {30'd0, mode_o}, 32'd3);
    pixel_check("scroll_00", 1'b1, 8'h00, 24'hFFFF00);
    pixel_check("scroll_E0", 1'b1, 8'hE0, 24'hFFFFFF);
    pixel_check("scroll_A0", 1'b1, 8'hA0, 24'h0000FF);
    de_in = 1'b0;
    step();

    // Debounced press lands on the same edge as a vsync fall.
    btn_n = 1'b0;
    repeat (5) step();
    vsync_in = 1'b0;
    step();
    check_val("coinc_same", {30'd0, mode_o}, 32'd3);
    step();
    vsync_in = 1'b1;
    btn_n    = 1'b1;
    repeat (8) step();
    frames++;
    check_val("coinc_hold", {30'd0, mode_o}, 32'd3);
    vsync_pulse();
    check_val("coinc_next", {30'd0, mode_o}, 32'd0);

    // Mid-frame asynchronous reset from mode 1.
    press(10);
    vsync_pulse();
    check_val("mode1_again", {30'd0, mode_o}, 32'd1);
    de_in  = 1'b1;
    blk_in = 8'h80;
    step();
    step();
    check_val("pre_rst", rgb(), 32'h00808080);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_rgb", rgb(), 32'd0);
    check_val("arst_de", {31'd0, de_o}, 32'd0);
    check_val("arst_mode", {30'd0, mode_o}, 32'd0);
    step();
    rst_n = 1'b1;
    pixel_check("post_rst", 1'b1, 8'h40, 24'h00FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-data stage directly downstream of the VGA timing driver.
- Consumes hsync/vsync/active-enable plus the 8-bit horizontal block index (0..255 across the active line).
- Produces 24-bit RGB with syncs and data-enable delay-matched to the colour data.
- Four test patterns, selected by a debounced push-button; pattern changes take effect only at frame boundaries.

Parameters:
DEBOUNCE_CYCLES, 400000, stable-level cycles required to accept a button change (10 ms at 40 MHz); counter is 20 bits wide.
INIT_MODE, 0, pattern mode loaded at reset (0..3).

Ports:
clk  input  1  pixel clock (40 MHz for 800x600)
rst_n  input  1  asynchronous active-low reset
hsync_in  input  1  horizontal sync from timing driver, active low
vsync_in  input  1  vertical sync from timing driver, active low
de_in  input  1  active-video flag (high inside 800x600 window)
blk_in  input  8  horizontal block index, valid when de_in=1
btn_n  input  1  asynchronous mode button, active low (pressed=0)
hsync_o  output  1  hsync_in delayed 2 cycles
vsync_o  output  1  vsync_in delayed 2 cycles
de_o  output  1  de_in delayed 2 cycles
vga_r  output  8  red
vga_g  output  8  green
vga_b  output  8  blue
mode_o  output  2  currently applied mode (for LEDs)

Behaviour:
- Reset (async, rst_n=0): hsync_o=1, vsync_o=1, de_o=0, RGB=0, mode_active=mode_pending=INIT_MODE, frame_cnt=0, line_cnt=0, debounce counter=0, debounced level=1, sync flops=1.
- Pipeline: stage 1 registers hsync/vsync/de/blk (_d1); stage 2 registers outputs. Fixed latency of 2 clk from inputs to all outputs; no bubbles, no back-pressure.
- Blanking: RGB=0 whenever de_d1=0, regardless of mode.
- Colour table, index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (RRGGBB).
- Mode 0 (colour bars): index = blk_d1[7:5].
- Mode 1 (gray ramp): R=G=B=blk_d1.
- Mode 2 (checker): (blk_d1[4] XOR line_cnt[5]) ? FFFFFF : 000000.
- Mode 3 (scrolling bars): index = (blk_d1 + frame_cnt) mod 256, bits [7:5].
- line_cnt (10 bit):
  - Cleared while vsync_d1=0.
  - Increments on a de falling edge (de_d1=1, de_in=0) and saturates at 1023.
  - Equals k during active line k, starting at 0.
- frame_cnt (8 bit): increments on a vsync falling edge (vsync_d1=1, vsync_in=0), in every mode; wraps 255 -> 0.
- Button:
  - btn_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synced level differs from the debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A debounced 1->0 transition sets mode_pending <= mode_pending+1 (mod 4). Release has no effect.
- Mode apply: on a vsync falling edge, mode_active <= mode_pending; mode_o = mode_active.
- Simultaneous press and vsync fall: mode_active takes the pre-increment pending value; the increment applies at the next frame.
- Multiple presses within one frame accumulate mod 4.
- Reset mid-frame: all state returns to reset values immediately. After release, output is valid from the first de_in cycle +2.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> hsync_o=1, vsync_o=1, de_o=0, RGB=000000, mode_o=INIT_MODE (0). Holds asynchronously without a clk edge.
- Latency/bars: mode 0, de_in=1, blk_in=0x40 at cycle n -> RGB=00FFFF at n+2. Pulse hsync_in low at n -> hsync_o low at n+2. blk_in=0xE0 -> 000000; blk_in=0x00 -> FFFFFF.
- Blanking: mode 1, de_in=0, blk_in=0x80 -> RGB=000000. Same with de_in=1 -> 808080.
- Debounce (DEBOUNCE_CYCLES=4): btn_n low for 2 cycles -> mode_o unchanged. btn_n low for 10 cycles -> mode_o stays 0 until vsync_in falls, then 1. Release -> no further change.
- Checker: mode 2, line 0, blk_in=0x10 -> FFFFFF. After 32 de_in pulses (line 32), blk_in=0x10 -> 000000. vsync_in low -> line_cnt returns to 0.
- Scroll + coincidence: mode 3 after 32 vsync falls (frame_cnt=32), blk_in=0x00 -> FFFF00. Debounced press landing in the same cycle as a vsync fall -> mode_o changes only at the following vsync fall.
